// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue stage's instruction handshake, register-file and ALU
// connections. The "slave" side is the issue stage; the "master" side is the
// surrounding environment (instruction source, register file and ALU).
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 5
);
  // Instruction handshake: a word transfers on a rising clock edge where
  // instr_valid and instr_ready are both 1. instr_valid may be raised at any
  // time and instr/instr_valid must stay stable until the transfer happens;
  // instr_ready never depends combinationally on instr_valid.
  logic [31:0]               instr;
  logic                      instr_valid;
  logic                      instr_ready;

  logic [REG_ADDR_WIDTH-1:0] rf_addr_r1;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r2;
  logic [DATA_WIDTH-1:0]     rf_data_r1;
  logic [DATA_WIDTH-1:0]     rf_data_r2;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_w;
  logic [DATA_WIDTH-1:0]     rf_data_w;
  logic                      rf_write;

  logic [DATA_WIDTH-1:0]     alu_op1;
  logic [DATA_WIDTH-1:0]     alu_op2;
  logic [OPRN_WIDTH-1:0]     alu_oprn;
  logic [DATA_WIDTH-1:0]     alu_out;
  logic                      alu_zero;

  logic [DATA_WIDTH-1:0]     result;
  logic                      zero_flag;
  logic                      done;
  logic                      err;

  modport slave (
    input  instr, instr_valid, rf_data_r1, rf_data_r2, alu_out, alu_zero,
    output instr_ready, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, rf_write,
           alu_op1, alu_op2, alu_oprn, result, zero_flag, done, err
  );

  modport master (
    output instr, instr_valid, rf_data_r1, rf_data_r2, alu_out, alu_zero,
    input  instr_ready, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, rf_write,
           alu_op1, alu_op2, alu_oprn, result, zero_flag, done, err
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Non-pipelined decode/issue stage in front of a combinational 32-bit ALU.
// One instruction is in flight at a time: IDLE accepts, DECODE reads the
// register file and registers the ALU inputs, EXEC captures the ALU result,
// WB strobes the write-back. Unsupported encodings pulse err and return.
module alu_issue_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]               instr_q;
  logic [REG_ADDR_WIDTH-1:0] wa_q;
  logic                      ready_c;
  logic                      done_c;
  logic                      write_c;

  // Instruction fields of the latched word.
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [REG_ADDR_WIDTH-1:0] rt_f;
  logic [REG_ADDR_WIDTH-1:0] rd_f;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [DATA_WIDTH-1:0] shamt_zext;
  logic [DATA_WIDTH-1:0] imm_upper;

  assign opcode     = instr_q[31:26];
  assign funct      = instr_q[5:0];
  assign shamt      = instr_q[10:6];
  assign imm        = instr_q[15:0];
  assign rt_f       = instr_q[20:16];
  assign rd_f       = instr_q[15:11];
  assign imm_sext   = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_zext   = {{(DATA_WIDTH-16){1'b0}}, imm};
  assign shamt_zext = {{(DATA_WIDTH-5){1'b0}}, shamt};
  assign imm_upper  = {imm, {(DATA_WIDTH-16){1'b0}}};

  // Read ports always follow the latched word; only DECODE consumes the data.
  assign bus.rf_addr_r1 = instr_q[25:21];
  assign bus.rf_addr_r2 = instr_q[20:16];

  logic                      dec_ok;
  logic [OPRN_WIDTH-1:0]     dec_oprn;
  logic [DATA_WIDTH-1:0]     dec_op1;
  logic [DATA_WIDTH-1:0]     dec_op2;
  logic [REG_ADDR_WIDTH-1:0] dec_wa;

  // Decode the latched word into ALU operands, op code and write address.
  always_comb begin
    dec_ok   = 1'b0;
    dec_oprn = '0;
    dec_op1  = bus.rf_data_r1;
    dec_op2  = bus.rf_data_r2;
    dec_wa   = rd_f;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20: begin dec_ok = 1'b1; dec_oprn = 6'd1; end
        6'h22: begin dec_ok = 1'b1; dec_oprn = 6'd2; end
        6'h2c: begin dec_ok = 1'b1; dec_oprn = 6'd3; end
        6'h02: begin dec_ok = 1'b1; dec_oprn = 6'd4; dec_op2 = shamt_zext; end
        6'h01: begin dec_ok = 1'b1; dec_oprn = 6'd5; dec_op2 = shamt_zext; end
        6'h24: begin dec_ok = 1'b1; dec_oprn = 6'd6; end
        6'h25: begin dec_ok = 1'b1; dec_oprn = 6'd7; end
        6'h27: begin dec_ok = 1'b1; dec_oprn = 6'd8; end
        6'h2a: begin dec_ok = 1'b1; dec_oprn = 6'd9; end
        default: dec_ok = 1'b0;
      endcase
    end else begin
      dec_wa = rt_f;
      case (opcode)
        6'h08: begin dec_ok = 1'b1; dec_oprn = 6'd1; dec_op2 = imm_sext; end
        6'h1d: begin dec_ok = 1'b1; dec_oprn = 6'd3; dec_op2 = imm_sext; end
        6'h0c: begin dec_ok = 1'b1; dec_oprn = 6'd6; dec_op2 = imm_zext; end
        6'h0d: begin dec_ok = 1'b1; dec_oprn = 6'd7; dec_op2 = imm_zext; end
        6'h0a: begin dec_ok = 1'b1; dec_oprn = 6'd9; dec_op2 = imm_sext; end
        6'h0f: begin
          dec_ok   = 1'b1;
          dec_oprn = 6'd1;
          dec_op1  = imm_upper;
          dec_op2  = '0;
        end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    done_c  = 1'b0;
    write_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = dec_ok ? S_EXEC : S_IDLE;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        done_c  = 1'b1;
        write_c = (bus.rf_addr_w != '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is held low while reset is asserted so nothing is offered early.
  assign bus.instr_ready = ready_c & rst_n;
  assign bus.done        = done_c;
  assign bus.rf_write    = write_c;
  assign state_dbg       = state_q;

  // Datapath registers: instruction latch, ALU inputs, result capture, err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q       <= '0;
      wa_q          <= '0;
      bus.alu_op1   <= '0;
      bus.alu_op2   <= '0;
      bus.alu_oprn  <= '0;
      bus.rf_data_w <= '0;
      bus.rf_addr_w <= '0;
      bus.result    <= '0;
      bus.zero_flag <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= (state_q == S_DECODE) && !dec_ok;
      if (state_q == S_IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state_q == S_DECODE && dec_ok) begin
        bus.alu_op1  <= dec_op1;
        bus.alu_op2  <= dec_op2;
        bus.alu_oprn <= dec_oprn;
        wa_q         <= dec_wa;
      end
      if (state_q == S_EXEC) begin
        bus.rf_data_w <= bus.alu_out;
        bus.rf_addr_w <= wa_q;
        bus.result    <= bus.alu_out;
        bus.zero_flag <= bus.alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: models the external register file and ALU,
// predicts each instruction's outcome from its architectural meaning and
// checks commits/errors from an independent monitor.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // environment register file
  logic [31:0] tb_rf [32] = '{default: '0};
  always @(posedge clk) if (bus.rf_write) tb_rf[bus.rf_addr_w] <= bus.rf_data_w;
  assign bus.rf_data_r1 = tb_rf[bus.rf_addr_r1];
  assign bus.rf_data_r2 = tb_rf[bus.rf_addr_r2];

  // environment ALU
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_oprn)
      6'd1: alu_res = bus.alu_op1 + bus.alu_op2;
      6'd2: alu_res = bus.alu_op1 - bus.alu_op2;
      6'd3: alu_res = bus.alu_op1 * bus.alu_op2;
      6'd4: alu_res = bus.alu_op1 >> bus.alu_op2[4:0];
      6'd5: alu_res = bus.alu_op1 << bus.alu_op2[4:0];
      6'd6: alu_res = bus.alu_op1 & bus.alu_op2;
      6'd7: alu_res = bus.alu_op1 | bus.alu_op2;
      6'd8: alu_res = ~(bus.alu_op1 | bus.alu_op2);
      6'd9: alu_res = ($signed(bus.alu_op1) < $signed(bus.alu_op2)) ? 32'd1 : 32'd0;
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_out  = alu_res;
  assign bus.alu_zero = (alu_res == 32'd0);

  // scoreboard
  typedef struct {
    logic        is_err;
    logic [4:0]  wa;
    logic [31:0] data;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  oprn;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] ref_rf [32] = '{default: '0};
  logic [31:0] last_res = '0;
  logic        last_zero = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of one instruction against the model register file.
  function automatic exp_t ref_model(input logic [31:0] ins);
    exp_t e;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] a, b, se, ze;
    op  = ins[31:26];
    fn  = ins[5:0];
    sh  = ins[10:6];
    imm = ins[15:0];
    a   = ref_rf[ins[25:21]];
    b   = ref_rf[ins[20:16]];
    se  = 32'($signed(imm));
    ze  = {16'h0000, imm};
    e.is_err = 1'b0;
    e.data = '0;
    e.oprn = '0;
    e.op1 = a;
    e.cyc = 0;
    if (op == 6'h00) begin
      e.wa  = ins[15:11];
      e.op2 = b;
      case (fn)
        6'h20: begin e.data = a + b; e.oprn = 1; end
        6'h22: begin e.data = a - b; e.oprn = 2; end
        6'h2c: begin e.data = a * b; e.oprn = 3; end
        6'h02: begin e.data = a >> sh; e.oprn = 4; e.op2 = 32'(sh); end
        6'h01: begin e.data = a << sh; e.oprn = 5; e.op2 = 32'(sh); end
        6'h24: begin e.data = a & b; e.oprn = 6; end
        6'h25: begin e.data = a | b; e.oprn = 7; end
        6'h27: begin e.data = ~(a | b); e.oprn = 8; end
        6'h2a: begin e.data = 32'($signed(a) < $signed(b)); e.oprn = 9; end
        default: e.is_err = 1'b1;
      endcase
    end else begin
      e.wa = ins[20:16];
      case (op)
        6'h08: begin e.data = a + se; e.oprn = 1; e.op2 = se; end
        6'h1d: begin e.data = a * se; e.oprn = 3; e.op2 = se; end
        6'h0c: begin e.data = a & ze; e.oprn = 6; e.op2 = ze; end
        6'h0d: begin e.data = a | ze; e.oprn = 7; e.op2 = ze; end
        6'h0a: begin e.data = 32'($signed(a) < $signed(se)); e.oprn = 9; e.op2 = se; end
        6'h0f: begin e.data = {imm, 16'h0}; e.oprn = 1; e.op1 = {imm, 16'h0}; e.op2 = 0; end
        default: e.is_err = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rf_write && !bus.done) check("stray_write", 32'(bus.rf_write), 32'd0);
      if (bus.done || bus.err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, bus.done, bus.err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_pulse", 32'(bus.err), 32'(e.is_err));
          check("done_pulse", 32'(bus.done), 32'(!e.is_err));
          check("latency", cyc, e.cyc);
          if (!e.is_err) begin
            check("rf_addr_w", 32'(bus.rf_addr_w), 32'(e.wa));
            check("rf_data_w", bus.rf_data_w, e.data);
            check("rf_write", 32'(bus.rf_write), 32'(e.wa != 0));
            check("result", bus.result, e.data);
            check("zero_flag", 32'(bus.zero_flag), 32'(e.data == 0));
            check("alu_op1", bus.alu_op1, e.op1);
            check("alu_op2", bus.alu_op2, e.op2);
            check("alu_oprn", 32'(bus.alu_oprn), 32'(e.oprn));
            if (e.wa != 0) ref_rf[e.wa] = e.data;
            last_res  = e.data;
            last_zero = (e.data == 0);
          end else begin
            check("err_result_held", bus.result, last_res);
            check("err_zero_held", 32'(bus.zero_flag), 32'(last_zero));
            check("err_no_write", 32'(bus.rf_write), 32'd0);
          end
        end
      end
    end
  end

  int unsigned accept_cyc;

  // driver: offer one word, wait for acceptance, push the expectation
  task automatic issue(input logic [31:0] ins, input bit keep_valid);
    exp_t e;
    int t;
    @(negedge clk);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    t = 0;
    while (!bus.instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      check("accept_timeout", 32'(t), 32'd0);
    end else begin
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      e = ref_model(ins);
      e.cyc = e.is_err ? cyc + 1 : cyc + 2;
      exp_q.push_back(e);
    end
    if (!keep_valid) begin
      bus.instr_valid = 1'b0;
      bus.instr = $urandom;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_result", bus.result, 32'd0);
    check("rst_zero_flag", 32'(bus.zero_flag), 32'd0);
    check("rst_rf_data_w", bus.rf_data_w, 32'd0);
    check("rst_rf_addr_w", 32'(bus.rf_addr_w), 32'd0);
    check("rst_alu_op1", bus.alu_op1, 32'd0);
    check("rst_alu_op2", bus.alu_op2, 32'd0);
    check("rst_alu_oprn", 32'(bus.alu_oprn), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rf_write", 32'(bus.rf_write), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1;
    int t;
    logic [5:0] r_fn [9] = '{6'h20, 6'h22, 6'h2c, 6'h02, 6'h01, 6'h24, 6'h25, 6'h27, 6'h2a};
    logic [5:0] i_op [6] = '{6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0a, 6'h0f};
    logic [5:0] bad_op [3] = '{6'h3f, 6'h02, 6'h23};
    logic [31:0] ins;

    bus.instr = '0;
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.instr_ready), 32'd1);

    // add with R1=5, R2=7
    issue(enc_i(6'h08, 5'd0, 5'd1, 16'd5), 0);
    issue(enc_i(6'h08, 5'd0, 5'd2, 16'd7), 0);
    issue(32'h00221820, 0);
    drain();
    check("add_result", bus.result, 32'd12);
    check("add_written", tb_rf[3], 32'd12);

    // sign vs zero extension
    issue(enc_i(6'h08, 5'd0, 5'd4, 16'h0010), 0);
    issue(enc_i(6'h08, 5'd4, 5'd5, 16'hffff), 0);
    drain();
    check("addi_sext_op2", bus.alu_op2, 32'hffffffff);
    check("addi_sext_result", bus.result, 32'h0000000f);
    issue(enc_i(6'h0d, 5'd4, 5'd5, 16'hffff), 0);
    drain();
    check("ori_zext_op2", bus.alu_op2, 32'h0000ffff);

    // lui and sll
    issue(enc_i(6'h0f, 5'd9, 5'd6, 16'h1234), 0);
    drain();
    check("lui_op1", bus.alu_op1, 32'h12340000);
    check("lui_result", bus.result, 32'h12340000);
    issue(enc_i(6'h08, 5'd0, 5'd11, 16'd1), 0);
    issue(enc_r(5'd11, 5'd0, 5'd12, 5'd4, 6'h01), 0);
    drain();
    check("sll_op2", bus.alu_op2, 32'd4);
    check("sll_oprn", 32'(bus.alu_oprn), 32'd5);

    // sub to zero, then to R0
    issue(enc_i(6'h08, 5'd0, 5'd7, 16'h0055), 0);
    issue(enc_r(5'd7, 5'd7, 5'd8, 5'd0, 6'h22), 0);
    drain();
    check("sub_zero_flag", 32'(bus.zero_flag), 32'd1);
    issue(enc_r(5'd7, 5'd7, 5'd0, 5'd0, 6'h22), 0);
    drain();
    check("r0_still_zero", tb_rf[0], 32'd0);

    // errors: bad opcode, bad funct
    issue(enc_i(6'h08, 5'd0, 5'd13, 16'h0abc), 0);
    issue(enc_i(6'h3f, 5'd1, 5'd2, 16'h1111), 0);
    issue(enc_r(5'd1, 5'd2, 5'd14, 5'd0, 6'h3f), 0);
    drain();
    check("err_result_kept", bus.result, 32'h00000abc);

    // back-to-back with instr_valid held high
    issue(enc_r(5'd1, 5'd2, 5'd15, 5'd0, 6'h20), 1);
    a1 = accept_cyc;
    issue(enc_r(5'd15, 5'd1, 5'd16, 5'd0, 6'h20), 0);
    check("b2b_spacing", accept_cyc - a1, 32'd4);
    drain();
    check("b2b_second", bus.result, 32'd17);

    // reset during EXEC of an add into R9
    issue(enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h20), 0);
    t = 0;
    while (state_dbg != 2'd2 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("reach_exec", 32'(state_dbg), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last_res = '0;
    last_zero = 1'b0;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_abort", 32'(bus.instr_ready), 32'd1);
    // R9 must still read as zero
    issue(enc_r(5'd9, 5'd0, 5'd10, 5'd0, 6'h25), 0);
    drain();
    check("abort_no_write", bus.result, 32'd0);

    // randomized mix
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0: ins = (($urandom_range(0, 1)) != 0)
               ? enc_i(bad_op[$urandom_range(0, 2)], 5'($urandom), 5'($urandom), 16'($urandom))
               : enc_r(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'h3f);
        1, 2, 3, 4: ins = enc_r(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                                5'($urandom_range(0, 15)), 5'($urandom),
                                r_fn[$urandom_range(0, 8)]);
        default: ins = enc_i(i_op[$urandom_range(0, 5)], 5'($urandom_range(0, 15)),
                             5'($urandom_range(0, 15)), 16'($urandom));
      endcase
      issue(ins, ($urandom_range(0, 3) == 0));
    end
    bus.instr_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
